control_unit: RTL and testbench

Hardwired Moore controller that sequences the Mini-SRC datapath through instruction fetch and execute, replacing the hand-driven control signal sequences used in datapath benches. It reads the opcode from the IR and drives every datapath strobe (bus-source selects, register enables, memory Read/Write, Gra/Grb/Grc/Rin/Rout/BAout, Cout, IncPC) one state per clock. It also provides Run/Stop control for halting the processor.

---
 rtl/control_unit_if.sv | 36 +++
 rtl/control_unit.sv | 185 ++++++++++++++++++
 tb/tb_control_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Mini-SRC control bundle: IR/stop in, datapath strobes and run out.
// The controller drives through master; the datapath listens through slave.
interface control_unit_if;
    logic [31:0] ir;
    logic        stop;
    logic        run;
    logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic        InPortout, Cout, BAout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin;
    logic        HIin, LOin, OutPortin, InPortin, CONin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic        IncPC, Read, Write;
    logic [4:0]  alu_op;

    modport master (
        input  ir, stop,
        output run,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        output InPortout, Cout, BAout,
        output PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin,
        output HIin, LOin, OutPortin, InPortin, CONin,
        output Gra, Grb, Grc, Rin, Rout,
        output IncPC, Read, Write, alu_op
    );

    modport slave (
        output ir, stop,
        input  run,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        input  InPortout, Cout, BAout,
        input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin,
        input  HIin, LOin, OutPortin, InPortin, CONin,
        input  Gra, Grb, Grc, Rin, Rout,
        input  IncPC, Read, Write, alu_op
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore controller for the Mini-SRC datapath.
// Fetch T0..T2, per-class execute states, sticky stop leading to HALT.
module control_unit #(
    parameter int OPW = 5
) (
    input  logic          clock,
    input  logic          clear,
    control_unit_if.master bus
);
    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [4:0] {
        S_RESET, S_T0, S_T1, S_T2,
        S_LD3, S_LD4, S_LD5, S_LD6, S_LD7,
        S_LDI3, S_LDI4, S_LDI5,
        S_ST3, S_ST4, S_ST5, S_ST6, S_ST7,
        S_R3, S_R4, S_R5,
        S_I3, S_I4, S_I5,
        S_HALT
    } state_t;

    state_t         state, nxt;
    logic           stop_q;
    logic           done;
    logic [OPW-1:0] op;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] imm_alu;

    assign op = bus.ir[31:27];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= S_RESET;
            stop_q <= 1'b0;
            op_q   <= '0;
        end else begin
            state  <= nxt;
            stop_q <= (nxt == S_T0) ? 1'b0 : (stop_q | bus.stop);
            if (state == S_T2)
                op_q <= op;
        end
    end

    always_comb begin
        nxt  = state;
        done = 1'b0;
        unique case (state)
            S_RESET: nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = S_T2;
            S_T2: begin
                case (op)
                    OP_LD:   nxt = S_LD3;
                    OP_LDI:  nxt = S_LDI3;
                    OP_ST:   nxt = S_ST3;
                    OP_ADD, OP_SUB,
                    OP_AND, OP_OR:
                             nxt = S_R3;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:  nxt = S_I3;
                    OP_HALT: nxt = S_HALT;
                    default: done = 1'b1;
                endcase
            end
            S_LD3:  nxt = S_LD4;
            S_LD4:  nxt = S_LD5;
            S_LD5:  nxt = S_LD6;
            S_LD6:  nxt = S_LD7;
            S_LD7:  done = 1'b1;
            S_LDI3: nxt = S_LDI4;
            S_LDI4: nxt = S_LDI5;
            S_LDI5: done = 1'b1;
            S_ST3:  nxt = S_ST4;
            S_ST4:  nxt = S_ST5;
            S_ST5:  nxt = S_ST6;
            S_ST6:  nxt = S_ST7;
            S_ST7:  done = 1'b1;
            S_R3:   nxt = S_R4;
            S_R4:   nxt = S_R5;
            S_R5:   done = 1'b1;
            S_I3:   nxt = S_I4;
            S_I4:   nxt = S_I5;
            S_I5:   done = 1'b1;
            S_HALT: nxt = S_HALT;
            default: nxt = S_RESET;
        endcase
        // a stop seen on this very edge still counts
        if (done)
            nxt = (stop_q | bus.stop) ? S_HALT : S_T0;
    end

    assign imm_alu = (op_q == OP_ANDI) ? OP_AND :
                     (op_q == OP_ORI)  ? OP_OR  : OP_ADD;

    always_comb begin
        bus.run       = (state != S_RESET) && (state != S_HALT);
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.MDRout    = 1'b0;
        bus.HIout     = 1'b0;
        bus.LOout     = 1'b0;
        bus.InPortout = 1'b0;
        bus.Cout      = 1'b0;
        bus.BAout     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.OutPortin = 1'b0;
        bus.InPortin  = 1'b0;
        bus.CONin     = 1'b0;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.alu_op    = '0;
        unique case (state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1;
                bus.IncPC = 1'b1; bus.PCin  = 1'b1;
            end
            S_T1: begin
                bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_LD3, S_LDI3, S_ST3: begin
                bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end
            S_LD4, S_LDI4, S_ST4: begin
                bus.Cout   = 1'b1; bus.Zlowin = 1'b1;
                bus.alu_op = OP_ADD;
            end
            S_LD5, S_ST5: begin
                bus.Zlowout = 1'b1; bus.MARin = 1'b1;
            end
            S_LD6: begin
                bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_LD7: begin
                bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
            S_ST6: begin
                bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
            end
            S_ST7: bus.Write = 1'b1;
            S_R3, S_I3: begin
                bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end
            S_R4: begin
                bus.Grc    = 1'b1; bus.Rout = 1'b1;
                bus.Zlowin = 1'b1; bus.alu_op = op_q;
            end
            S_I4: begin
                bus.Cout   = 1'b1; bus.Zlowin = 1'b1;
                bus.alu_op = imm_alu;
            end
            S_LDI5, S_R5, S_I5: begin
                bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction strobe tables checked each cycle.
// Directed plan items first, then randomized instruction streams with stop.
module tb_control_unit;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   total = 0;
    int   bad   = 0;

    control_unit_if bus ();

    control_unit dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    localparam logic [34:0] B1 = 35'd1;
    localparam logic [34:0] PCOUT   = B1 << 0;
    localparam logic [34:0] ZLOWOUT = B1 << 1;
    localparam logic [34:0] MDROUT  = B1 << 3;
    localparam logic [34:0] COUT    = B1 << 7;
    localparam logic [34:0] BAOUT   = B1 << 8;
    localparam logic [34:0] PCIN    = B1 << 9;
    localparam logic [34:0] MARIN   = B1 << 10;
    localparam logic [34:0] MDRIN   = B1 << 11;
    localparam logic [34:0] IRIN    = B1 << 12;
    localparam logic [34:0] YIN     = B1 << 13;
    localparam logic [34:0] ZLOWIN  = B1 << 14;
    localparam logic [34:0] GRA     = B1 << 21;
    localparam logic [34:0] GRB     = B1 << 22;
    localparam logic [34:0] GRC     = B1 << 23;
    localparam logic [34:0] RIN     = B1 << 24;
    localparam logic [34:0] ROUT    = B1 << 25;
    localparam logic [34:0] INCPC   = B1 << 26;
    localparam logic [34:0] READ    = B1 << 27;
    localparam logic [34:0] WRITE   = B1 << 28;
    localparam logic [34:0] RUN     = B1 << 29;

    localparam logic [4:0] LD = 5'd0, LDI = 5'd1, ST = 5'd2;
    localparam logic [4:0] ADD = 5'd3, SUB = 5'd4, AND_ = 5'd5;
    localparam logic [4:0] OR_ = 5'd6, ADDI = 5'd12, ANDI = 5'd13;
    localparam logic [4:0] ORI = 5'd14, NOP = 5'd26, HALT = 5'd27;

    logic [4:0] oplist [12] = '{LD, LDI, ST, ADD, SUB, AND_, OR_,
                                ADDI, ANDI, ORI, NOP, HALT};

    function automatic logic [34:0] obs();
        return {bus.alu_op, bus.run, bus.Write, bus.Read, bus.IncPC,
                bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                bus.CONin, bus.InPortin, bus.OutPortin, bus.LOin,
                bus.HIin, bus.Zhighin, bus.Zlowin, bus.Yin, bus.IRin,
                bus.MDRin, bus.MARin, bus.PCin, bus.BAout, bus.Cout,
                bus.InPortout, bus.LOout, bus.HIout, bus.MDRout,
                bus.Zhighout, bus.Zlowout, bus.PCout};
    endfunction

    function automatic logic [34:0] alu(input logic [4:0] v);
        return {v, 30'd0};
    endfunction

    function automatic bit is_r(input logic [4:0] op);
        return op == ADD || op == SUB || op == AND_ || op == OR_;
    endfunction

    function automatic bit is_i(input logic [4:0] op);
        return op == ADDI || op == ANDI || op == ORI;
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        if (op == LD || op == ST) return 8;
        if (op == LDI || is_r(op) || is_i(op)) return 6;
        return 3;
    endfunction

    // Expected strobe word for cycle k of an instruction, counted from T0
    function automatic logic [34:0] expect_word(input logic [4:0] op,
                                                input int k);
        logic [34:0] w;
        logic [4:0]  iop;
        w = RUN;
        iop = (op == ANDI) ? AND_ : (op == ORI) ? OR_ : ADD;
        if (k == 0) return w | PCOUT | MARIN | INCPC | PCIN;
        if (k == 1) return w | READ | MDRIN;
        if (k == 2) return w | MDROUT | IRIN;
        if (op == LD || op == ST || op == LDI) begin
            if (k == 3) return w | GRB | BAOUT | YIN;
            if (k == 4) return w | COUT | ZLOWIN | alu(ADD);
            if (op == LDI) return w | ZLOWOUT | GRA | RIN;
            if (k == 5) return w | ZLOWOUT | MARIN;
            if (op == LD && k == 6) return w | READ | MDRIN;
            if (op == LD) return w | MDROUT | GRA | RIN;
            if (k == 6) return w | GRA | ROUT | MDRIN;
            return w | WRITE;
        end
        if (k == 3) return w | GRB | ROUT | YIN;
        if (k == 5) return w | ZLOWOUT | GRA | RIN;
        if (is_r(op)) return w | GRC | ROUT | ZLOWIN | alu(op);
        return w | COUT | ZLOWIN | alu(iop);
    endfunction

    task automatic check(input string tag, input logic [34:0] o,
                         input logic [34:0] e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, o, e);
        end
    endtask

    task automatic do_reset();
        clear = 1'b0;
        bus.stop = 1'b0;
        #1 check("clr_async", obs(), '0);
        @(negedge clock);
        check("rst_state", obs(), '0);
        clear = 1'b1;
    endtask

    task automatic run_instr(input logic [4:0] op, input int stop_k,
                             input int abort_k);
        int n;
        logic [31:0] r;
        n = instr_len(op);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (k == 0) begin
                r = $urandom();
                bus.ir = {op, r[26:0]};
            end
            check($sformatf("op%0d_c%0d", op, k), obs(),
                  expect_word(op, k));
            if (k == abort_k) begin
                clear = 1'b0;
                #1 check("abort", obs(), '0);
                return;
            end
            bus.stop = (k == stop_k);
        end
        if (stop_k >= 0 || op == HALT) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clock);
                bus.stop = 1'b0;
                check("halted", obs(), '0);
            end
            do_reset();
        end
    endtask

    initial begin
        logic [4:0] op;
        int sk;
        bus.ir = '0;
        bus.stop = 1'b0;
        @(negedge clock);
        do_reset();
        run_instr(LD, -1, -1);
        run_instr(LDI, -1, -1);
        run_instr(ADD, -1, -1);
        run_instr(ADDI, -1, -1);
        run_instr(ST, -1, -1);
        run_instr(5'b11111, -1, -1);
        run_instr(NOP, -1, -1);
        run_instr(LD, 4, -1);
        run_instr(ST, -1, 7);
        do_reset();
        run_instr(ANDI, -1, -1);
        run_instr(ORI, 7 - 2, -1);
        run_instr(SUB, 0, -1);
        run_instr(HALT, -1, -1);
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 14);
            op = (r < 12) ? oplist[r] : 5'($urandom_range(0, 31));
            sk = -1;
            if ($urandom_range(0, 7) == 0)
                sk = $urandom_range(0, instr_len(op) - 1);
            run_instr(op, sk, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
